// File: rtl/i2c_slave_reg_responder.sv
// I2C target at SLAVE_ADDR serving a 4-byte register bank at REG_BASE.
// SCL/SDA are oversampled on clk_200khz; the pointer auto-increments per byte.
module i2c_slave_reg_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter logic [7:0] REG_BASE   = 8'h3C
) (
  input  logic        clk_200khz,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  output logic        sda_dir,
  input  logic [15:0] data_in,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  ptr, ptr_n;
  logic [7:0]  scr0, scr0_n, scr1, scr1_n;
  logic [15:0] snap, snap_n;
  logic [7:0]  tx, tx_n;
  logic        out_bit, out_n, dir_n, strobe_n, busy_n;
  logic [7:0]  waddr_n, wdata_n, byte_in;
  logic [2:0]  scl_q, sda_q;
  logic        scl_rise, scl_fall, start_det, stop_det, shifting;

  assign sda = sda_dir ? out_bit : 1'bz;

  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  // SDA edges only count as START/STOP while SCL is stably high
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign shifting  = (state == ADDR) || (state == REG) ||
                     (state == WDATA) || (state == RDATA);
  assign byte_in   = {shreg[6:0], sda_q[1]};

  function automatic logic [7:0] rd_byte(input logic [7:0]  p,
                                         input logic [15:0] s,
                                         input logic [7:0]  s0,
                                         input logic [7:0]  s1);
    logic [7:0] off;
    logic [7:0] r;
    off = p - REG_BASE;
    case (off)
      8'd0:    r = s[15:8];
      8'd1:    r = s[7:0];
      8'd2:    r = s0;
      8'd3:    r = s1;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    ptr_n    = ptr;
    scr0_n   = scr0;
    scr1_n   = scr1;
    snap_n   = snap;
    tx_n     = tx;
    out_n    = out_bit;
    dir_n    = sda_dir;
    strobe_n = 1'b0;
    waddr_n  = wr_addr;
    wdata_n  = wr_data;
    busy_n   = busy;
    if (start_det) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      dir_n   = 1'b0;
      out_n   = 1'b1;
      busy_n  = 1'b1;
    end else if (stop_det) begin
      state_n = IDLE;
      dir_n   = 1'b0;
      out_n   = 1'b1;
      busy_n  = 1'b0;
    end else begin
      if (scl_rise && shifting) begin
        cnt_n   = cnt + 4'd1;
        shreg_n = byte_in;
      end
      unique case (state)
        ADDR: if (scl_fall && cnt == 4'd8) begin
          if (shreg[7:1] == SLAVE_ADDR) begin
            state_n = ADDR_ACK;
            dir_n   = 1'b1;
            out_n   = 1'b0;
          end else begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_n = 4'd0;
          if (shreg[0]) begin
            state_n = RDATA;
            snap_n  = data_in;
            tx_n    = rd_byte(ptr, data_in, scr0, scr1);
            out_n   = tx_n[7];
            dir_n   = 1'b1;
          end else begin
            state_n = REG;
            dir_n   = 1'b0;
            out_n   = 1'b1;
          end
        end
        REG: if (scl_fall && cnt == 4'd8) begin
          ptr_n   = shreg;
          state_n = REG_ACK;
          dir_n   = 1'b1;
          out_n   = 1'b0;
        end
        REG_ACK, WDATA_ACK: if (scl_fall) begin
          state_n = WDATA;
          cnt_n   = 4'd0;
          dir_n   = 1'b0;
          out_n   = 1'b1;
        end
        WDATA: begin
          if (scl_rise && cnt == 4'd7) begin
            strobe_n = 1'b1;
            waddr_n  = ptr;
            wdata_n  = byte_in;
            ptr_n    = ptr + 8'd1;
            if (ptr == REG_BASE + 8'd2) scr0_n = byte_in;
            if (ptr == REG_BASE + 8'd3) scr1_n = byte_in;
          end
          if (scl_fall && cnt == 4'd8) begin
            state_n = WDATA_ACK;
            dir_n   = 1'b1;
            out_n   = 1'b0;
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt == 4'd8) begin
            state_n = RDATA_ACK;
            dir_n   = 1'b0;
            out_n   = 1'b1;
            ptr_n   = ptr + 8'd1;
          end else if (cnt != 4'd0) begin
            out_n = tx[3'd7 - cnt[2:0]];
          end
        end
        RDATA_ACK: begin
          if (scl_rise && sda_q[1]) begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end else if (scl_fall) begin
            state_n = RDATA;
            cnt_n   = 4'd0;
            tx_n    = rd_byte(ptr, snap, scr0, scr1);
            out_n   = tx_n[7];
            dir_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      shreg     <= 8'd0;
      ptr       <= REG_BASE;
      scr0      <= 8'd0;
      scr1      <= 8'd0;
      snap      <= 16'd0;
      tx        <= 8'hFF;
      out_bit   <= 1'b1;
      sda_dir   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      scr0      <= scr0_n;
      scr1      <= scr1_n;
      snap      <= snap_n;
      tx        <= tx_n;
      out_bit   <= out_n;
      sda_dir   <= dir_n;
      wr_strobe <= strobe_n;
      wr_addr   <= waddr_n;
      wr_data   <= wdata_n;
      busy      <= busy_n;
    end
  end

endmodule
